// File: rtl/clk_rec_pkg.sv
// clk_rec_pkg: shared types and constants for the bit-clock-recovery
// acquisition/lock controller (state encoding, default widths).
package clk_rec_pkg;

    localparam int CLK_REC_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        TRACK    = 2'd2,
        HOLDOVER = 2'd3
    } clk_rec_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_rec_watchdog.sv
// clk_rec_watchdog: saturating edge-free cycle counter with clear,
// exposing timeout and holdover threshold hits.
module clk_rec_watchdog
    import clk_rec_pkg::*;
#(
    parameter int TIMEOUT = 65535,
    parameter int HOLD    = 262143
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic timeout_hit_o,
    output logic hold_hit_o
);

    localparam int MAXC = max_int(TIMEOUT, HOLD);
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count idle cycles, holding at the larger threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(MAXC)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit_o = (cnt_q >= CW'(TIMEOUT));
    assign hold_hit_o    = (cnt_q >= CW'(HOLD));

endmodule

// File: rtl/clk_rec_ctrl.sv
// clk_rec_ctrl: acquisition/lock FSM driving the recovered-clock divider.
// Optional glitch filter: define CLK_REC_CTRL_GLITCH_EN.
module clk_rec_ctrl
    import clk_rec_pkg::*;
#(
    parameter int W            = CLK_REC_W,
    parameter int ACQ_EDGES    = 64,
    parameter int LOCK_EDGES   = 4096,
    parameter int TIMEOUT      = 65535,
    parameter int HOLD         = 262143,
    parameter int MIN_INTERVAL = 2
) (
    input  logic         clk_200M,
    input  logic         rst_n,
    input  logic         en,
    input  logic         edge_stb,
    input  logic [W-1:0] interval,
    output logic [W-1:0] bit_period,
    output logic         nco_en,
    output logic         locked,
    output logic         lost_lock,
    output logic [1:0]   state
);

    localparam int ECW = $clog2(ACQ_EDGES + 1);
    localparam int SCW = $clog2(LOCK_EDGES + 1);

`ifdef CLK_REC_CTRL_GLITCH_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    clk_rec_state_t state_q, state_d;
    logic [W-1:0]   min_q, min_d;
    logic [W-1:0]   bp_q, bp_d;
    logic [ECW-1:0] ecnt_q, ecnt_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic           nco_q, nco_d;
    logic           lock_q, lock_d;
    logic           lost_q, lost_d;

    logic           act;
    logic           glitch;
    logic           acc;
    logic [W-1:0]   min_new;
    logic [ECW-1:0] ecnt_inc;
    logic [SCW-1:0] scnt_inc;
    logic [W-1:0]   bp_rel;
    logic           wd_clr;
    logic           to_hit;
    logic           hold_hit;

    // Any non-zero interval is signal activity; short ones may be filtered.
    assign act      = edge_stb && (interval != '0);
    assign glitch   = GLITCH_EN && (interval < W'(MIN_INTERVAL));
    assign acc      = act && !glitch;
    assign min_new  = (interval < min_q) ? interval : min_q;
    assign ecnt_inc = ecnt_q + ECW'(1);
    assign scnt_inc = scnt_q + SCW'(1);
    assign bp_rel   = (bp_q == '1) ? bp_q : bp_q + W'(1);

    // Watchdog restarts on activity, on any state change and while idle.
    assign wd_clr = act || (state_d != state_q) || (state_q == IDLE);

    clk_rec_watchdog #(
        .TIMEOUT(TIMEOUT),
        .HOLD   (HOLD)
    ) u_wd (
        .clk_i        (clk_200M),
        .rst_ni       (rst_n),
        .clr_i        (wd_clr),
        .timeout_hit_o(to_hit),
        .hold_hit_o   (hold_hit)
    );

    // Next-state, period tracking and lock decisions.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        bp_d    = bp_q;
        ecnt_d  = ecnt_q;
        scnt_d  = scnt_q;
        nco_d   = nco_q;
        lock_d  = lock_q;
        lost_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            min_d   = '1;
            bp_d    = '1;
            ecnt_d  = '0;
            scnt_d  = '0;
            nco_d   = 1'b0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    min_d   = '1;
                    ecnt_d  = '0;
                end
                ACQUIRE: begin
                    if (acc) begin
                        min_d  = min_new;
                        ecnt_d = ecnt_inc;
                        if (ecnt_inc == ECW'(ACQ_EDGES)) begin
                            bp_d    = min_new;
                            nco_d   = 1'b1;
                            scnt_d  = '0;
                            state_d = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (acc) begin
                        if (interval < bp_q) begin
                            bp_d   = interval;
                            scnt_d = '0;
                            lock_d = 1'b0;
                        end else if (scnt_inc == SCW'(LOCK_EDGES)) begin
                            bp_d   = bp_rel;
                            scnt_d = '0;
                            lock_d = 1'b1;
                        end else begin
                            scnt_d = scnt_inc;
                        end
                    end else if (!act && to_hit) begin
                        state_d = HOLDOVER;
                        lost_d  = 1'b1;
                        lock_d  = 1'b0;
                    end
                end
                HOLDOVER: begin
                    if (acc) begin
                        state_d = TRACK;
                        scnt_d  = '0;
                    end else if (!act && hold_hit) begin
                        state_d = ACQUIRE;
                        nco_d   = 1'b0;
                        min_d   = '1;
                        ecnt_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            min_q   <= '1;
            bp_q    <= '1;
            ecnt_q  <= '0;
            scnt_q  <= '0;
            nco_q   <= 1'b0;
            lock_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            bp_q    <= bp_d;
            ecnt_q  <= ecnt_d;
            scnt_q  <= scnt_d;
            nco_q   <= nco_d;
            lock_q  <= lock_d;
            lost_q  <= lost_d;
        end
    end

    assign bit_period = bp_q;
    assign nco_en     = nco_q;
    assign locked     = lock_q;
    assign lost_lock  = lost_q;
    assign state      = state_q;

endmodule

// File: doc/clk_rec_ctrl.md
# clk_rec_ctrl

Acquisition/lock controller for the bit-clock-recovery datapath in the `clk_200M` domain. Consumes per-edge interval measurements from the edge/interval counter and drives the recovered-clock divider:
- supplies the `bit_period` compare value and enable;
- tracks drift;
- reports lock;
- handles signal loss through holdover and re-acquisition.

## Interface
Parameters:
- W, 16, width of interval/period values
- ACQ_EDGES, 64, valid edges sampled in ACQUIRE before first period is committed
- LOCK_EDGES, 4096, consecutive non-tightening edges in TRACK before `locked` asserts; also drift-release interval
- TIMEOUT, 65535, edge-free cycles in TRACK before entering HOLDOVER
- HOLD, 262143, edge-free cycles in HOLDOVER before falling back to ACQUIRE
- MIN_INTERVAL, 2, smallest accepted interval (glitch filter only)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_200M, in, 1, base clock
  - rst_n, in, 1, async active-low reset
- en, in, 1, controller enable; low forces IDLE
- edge_stb, in, 1, one-cycle pulse: datapath detected an edge
- interval, in, W, cycles since previous edge; valid only with edge_stb
- bit_period, out, W, divider compare value
- nco_en, out, 1, divider enable
- locked, out, 1, lock indication
- lost_lock, out, 1, one-cycle pulse on TRACK→HOLDOVER
- state, out, 2, current state code (debug)

## Operation
States: IDLE=0, ACQUIRE=1, TRACK=2, HOLDOVER=3.

- **IDLE**
  - Outputs held at reset values.
  - `en`=1 → ACQUIRE; `min_reg`←all-ones; `edge_cnt`←0.
- **ACQUIRE**
  - Each accepted edge: `min_reg`←min(`min_reg`, `interval`); `edge_cnt`++.
  - On the accepted edge that makes `edge_cnt`==ACQ_EDGES:
    - `bit_period`←min(`min_reg`, `interval`);
    - `nco_en`←1; `stable_cnt`←0; → TRACK.
  - No timeout in ACQUIRE.
- **TRACK**
  - Accepted edge with `interval` < `bit_period`:
    - `bit_period`←`interval` (tighten);
    - `stable_cnt`←0; `locked`←0.
  - Otherwise `stable_cnt`++.
  - When `stable_cnt` reaches LOCK_EDGES:
    - `locked`←1;
    - `bit_period`←`bit_period`+1, saturating at all-ones (drift release);
    - `stable_cnt`←0.
  - `locked` stays 1 through later releases until a tighten or state exit.
  - TIMEOUT cycles with no `edge_stb`:
    - → HOLDOVER; `lost_lock`=1 for one cycle;
    - `locked`←0; `bit_period` frozen; `nco_en` stays 1.
- **HOLDOVER**
  - Any accepted edge → TRACK with `stable_cnt`←0. That edge is not used for tightening.
  - HOLD edge-free cycles → ACQUIRE; `nco_en`←0; `min_reg`/`edge_cnt` reinitialised.
- **Acceptance**
  - An edge is accepted when `edge_stb`=1 and `interval`≠0.
  - `interval`=0 is always ignored and does not reset the watchdog.
- **Watchdog**
  - Counter clears on every `edge_stb` and on each state entry.
  - Otherwise it increments, saturating at max(TIMEOUT, HOLD).
- **Precedence**
  - `en`=0 beats everything: → IDLE next cycle, including mid-acquisition. Counters and `locked` clear; `bit_period` returns to all-ones.
  - Edge beats timeout/hold expiry in the same cycle.
  - Tighten beats drift release in the same cycle.
- **Counter widths**
  - `edge_cnt` ≥ clog2(ACQ_EDGES+1).
  - `stable_cnt` ≥ clog2(LOCK_EDGES+1).

## Timing
- All outputs registered.
- Reset values: `bit_period`=all-ones, `nco_en`=0, `locked`=0, `lost_lock`=0, `state`=IDLE.
- Edge-driven update latency is 1 cycle: values sampled at edge N appear on outputs at edge N+1.
- Edges back-to-back every cycle are supported.
- `lost_lock` asserts in the same cycle `state` first reads HOLDOVER.
- Timeout fires when the edge-free count reaches TIMEOUT, i.e. on cycle TIMEOUT+1 after the last edge.

## Configuration
- `CLK_REC_CTRL_GLITCH_EN`
  - Defined: edges with `interval` < MIN_INTERVAL are not accepted. They do not update `min_reg`/`bit_period` and do not count. They do clear the watchdog, because they still show signal activity.
  - Undefined: MIN_INTERVAL is unused; every non-zero interval is accepted.

## Structure
- Shared package `clk_rec_pkg`:
  - state enum `clk_rec_state_t` (IDLE/ACQUIRE/TRACK/HOLDOVER);
  - default width constant `CLK_REC_W`=16.
- Sub-module `clk_rec_watchdog`:
  - saturating edge-free counter with clear input;
  - two threshold compare outputs (`timeout_hit`, `hold_hit`).
- FSM and min/drift logic stay in `clk_rec_ctrl`.

## Test plan
Bench parameters: ACQ_EDGES=8, LOCK_EDGES=16, TIMEOUT=1000, HOLD=2000.
1. Reset, `en`=1, 8 edges with intervals 40,20,60,20,40,20,80,20 → TRACK, `bit_period`=20, `nco_en`=1 one cycle after 8th edge.
2. In TRACK, 16 edges of interval 20 → `locked`=1 and `bit_period`=21. Then an edge with interval 19 → `bit_period`=19, `locked`=0.
3. Locked at 20, then no edges for 1001 cycles → `lost_lock` pulse, `state`=3, `bit_period`=20, `nco_en`=1. Edge at +500 → `state`=2.
4. In HOLDOVER, no edges for 2001 cycles → `state`=1, `nco_en`=0, `bit_period` unchanged until the next commit.
5. With `CLK_REC_CTRL_GLITCH_EN` defined, MIN_INTERVAL=2, interval=1 during ACQUIRE → `edge_cnt` unchanged, `min_reg` unchanged. Without the macro → committed `bit_period`=1.
6. Drop `en` mid-ACQUIRE after 5 edges, and also assert `rst_n`=0 mid-TRACK → both yield `state`=0, `bit_period`=16'hFFFF, `locked`=0.
